uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Shares the single `uart_tx_8n1` transmitter among `N_REQ` byte-producing requesters (sensor reporters, status monitors). It arbitrates round-robin, frames each granted byte as an optional `<id>:` tag, the data byte and an optional end-of-line character, and sequences `tx_start` against `tx_busy` one character at a time. It sits between the sensor/report logic and `uart_tx_8n1` in `top`, and replaces the ad-hoc per-design timer/newline sequencing.

## Interface
- `N_REQ`, default 4: number of requesters. Legal range 1..10, so the tag is a single ASCII digit.
- `TAG_EN`, default 1: when 1, prefix each frame with `'0'+id` and `':'`.
- `EOL_CHAR`, default 8'h0A: character sent after data when the latched `eol` is 1.
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for `tx_busy` to rise after a `tx_start` pulse.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; the block has one clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  N_REQ  request i has a byte pending; held until `req_ready[i]`.
- `req_data`  in  8*N_REQ  byte for request i at `[8i+7:8i]`; stable while valid.
- `req_eol`  in  N_REQ  append `EOL_CHAR` after the byte.
- `req_ready`  out  N_REQ  one-cycle pulse, one-hot: byte i captured.
- `tx_start`  out  1  one-cycle start pulse to the UART.
- `tx_data`  out  8  character to the UART; stable from `tx_start` until the character completes.
- `tx_busy`  in  1  UART busy.
- `grant_id`  out  clog2(N_REQ) (min 1)  requester currently owning the UART.
- `active`  out  1  a frame is in progress (state is not IDLE).
- `err_timeout`  out  1  one-cycle pulse when an ACK timeout aborts a frame.

## Operation
- **States:** IDLE, GRANT, SEND, WAIT_ACK, WAIT_DONE.
- **IDLE:** if any `req_valid` is high, go to GRANT.
- **GRANT (1 cycle):**
  - Pick the winner by round-robin, searching from `last+1` with wrap-around past `N_REQ-1`.
  - Latch its data, eol and id. Set `last` to the winner. Pulse `req_ready[winner]`.
  - Set `phase` to TAG if `TAG_EN`, otherwise DATA. Go to SEND.
- **SEND:**
  - If `tx_busy`=1, hold in SEND and do not pulse.
  - Otherwise drive `tx_data` for the current phase and pulse `tx_start`, then go to WAIT_ACK with the timeout counter cleared.
  - Phase characters: TAG = 8'h30+id, COLON = 8'h3A, DATA = latched byte, EOL = `EOL_CHAR`.
- **WAIT_ACK:**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `ACK_TIMEOUT`, pulse `err_timeout` and go to IDLE; the rest of the frame is dropped.
- **WAIT_DONE:** when `tx_busy`=0, advance the phase and return to SEND, or go to IDLE.
  - Phase order: TAG, COLON, DATA, then EOL if latched eol=1; otherwise IDLE.
- **Grant hold:** a grant is held for the whole frame. `req_valid` changes during a frame have no effect until the next IDLE.
- **Dropped requests:** if `req_valid[i]` drops before `req_ready[i]`, the request is not captured and nothing is sent.
- **Counter width:** the timeout counter is `clog2(ACK_TIMEOUT+1)` bits and saturates; it never wraps.

## Timing
- **Reset values:**
  - `tx_start`=0, `tx_data`=8'h00, `req_ready`=0, `grant_id`=0, `active`=0, `err_timeout`=0.
  - State = IDLE, `last`=N_REQ-1, so the first grant goes to requester 0.
- **Latency** (`req_valid` high at edge k with the UART idle):
  - `req_ready` high in cycle k+1 (GRANT).
  - `tx_start` high in cycle k+2.
- **Back-to-back characters:** the next `tx_start` comes 1 cycle after the cycle in which `tx_busy` is seen low in WAIT_DONE.
- **Frame-to-frame:** minimum 2 cycles from the last `tx_busy` fall to the next `req_ready` (WAIT_DONE→IDLE→GRANT).
- **`tx_start` rules:** never asserted in two consecutive cycles, and never while `tx_busy`=1.
- **Reset mid-frame:** all outputs return to reset values asynchronously. The partial frame is not resumed, and the UART completes or aborts on its own reset.
- **Simultaneous events:** if `req_valid` rises in the same cycle the frame finishes, it is served on the next IDLE pass, with no loss.

## Structure
- Package `uart_sched_pkg` holds:
  - the state enum and the phase enum (TAG, COLON, DATA, EOL);
  - constants `ASCII_ZERO`=8'h30, `ASCII_COLON`=8'h3A, `ASCII_LF`=8'h0A.
- Sub-module `rr_arbiter`, parameterized by `N_REQ`:
  - inputs `req`, `last`;
  - outputs `gnt_onehot`, `gnt_id`, `any`.
  - It is purely combinational; `last` is a register in the parent.
- Top-level integration: `top` instantiates `uart_tx_scheduler` between `ir_sensor_input` reporters and `uart_tx_8n1`.

## Test plan
- **Single tagged request:** `N_REQ`=4, `TAG_EN`=1, `req_valid[2]`=1 with data 8'h31 and eol=1, UART model busy for 10 cycles per character. Required: characters 8'h32, 8'h3A, 8'h31, 8'h0A in order; one `req_ready[2]` pulse in cycle k+1; `tx_start` in cycle k+2.
- **Round-robin fairness:** all four requesters valid continuously with `TAG_EN`=0. Required: grant order 0,1,2,3,0,1; one `req_ready` pulse per frame.
- **ACK timeout:** UART model never raises `tx_busy`. Required: `err_timeout` pulse exactly 16 cycles after `tx_start`, state returns to IDLE, and the next request is served normally.
- **Busy at SEND:** `tx_busy` already high at SEND. Required: no `tx_start` until `tx_busy` falls, then exactly one pulse.
- **Reset mid-frame:** assert `rst_n`=0 during the COLON character. Required: all outputs at reset values immediately; after release, the first grant goes to requester 0.
- **Withdrawn request:** `req_valid[1]` pulses high for 1 cycle while requester 0's frame is in progress. Required: requester 1 never gets `req_ready` and nothing is sent for it.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared types, constants and helpers for the
// UART TX scheduler (states, frame phases, phase characters).
package uart_sched_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_GRANT     = 3'd1;
   localparam state_t ST_SEND      = 3'd2;
   localparam state_t ST_WAIT_ACK  = 3'd3;
   localparam state_t ST_WAIT_DONE = 3'd4;

   typedef enum logic [1:0] {
      PH_TAG   = 2'd0,
      PH_COLON = 2'd1,
      PH_DATA  = 2'd2,
      PH_EOL   = 2'd3
   } phase_e;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   function automatic logic [7:0] phase_char(
      input phase_e     ph,
      input logic [7:0] id,
      input logic [7:0] data,
      input logic [7:0] eol_char
   );
      logic [7:0] c;
      unique case (ph)
         PH_TAG:   c = ASCII_ZERO + id;
         PH_COLON: c = ASCII_COLON;
         PH_DATA:  c = data;
         default:  c = eol_char;
      endcase
      return c;
   endfunction

   function automatic logic phase_is_last(
      input phase_e ph,
      input logic   eol
   );
      return (ph == PH_EOL) || ((ph == PH_DATA) && !eol);
   endfunction

   function automatic phase_e phase_next(input phase_e ph);
      phase_e n;
      unique case (ph)
         PH_TAG:   n = PH_COLON;
         PH_COLON: n = PH_DATA;
         default:  n = PH_EOL;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward
// from last+1 and wrapping; the last pointer lives in the parent.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IDW-1:0]   gnt_id,
   output logic             any
);

   logic           hi_any;
   logic [IDW-1:0] hi_id;
   logic [IDW-1:0] lo_id;

   // lowest requester above last wins, else lowest overall
   always_comb begin
      hi_any = 1'b0;
      hi_id  = '0;
      lo_id  = '0;
      any    = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            any   = 1'b1;
            lo_id = IDW'(i);
            if (IDW'(i) > last) begin
               hi_any = 1'b1;
               hi_id  = IDW'(i);
            end
         end
      end
      gnt_id     = hi_any ? hi_id : lo_id;
      gnt_onehot = any ? (N_REQ'(1) << gnt_id) : '0;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one 8N1 transmitter among requesters,
// framing each byte as optional "<id>:" tag, data, optional EOL.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int         N_REQ       = 4,
   parameter bit         TAG_EN      = 1'b1,
   parameter logic [7:0] EOL_CHAR    = ASCII_LF,
   parameter int         ACK_TIMEOUT = 16,
   localparam int        IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_eol,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic [IDW-1:0]     grant_id,
   output logic               active,
   output logic               err_timeout
);

   localparam int             CW      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0]  TO_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0]  CNT_MAX = '1;
   localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

   state_t         state_q, state_d;
   phase_e         phase_q, phase_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] id_q, id_d;
   logic [7:0]     data_q, data_d;
   logic           eol_q, eol_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [N_REQ-1:0] gnt_oh;
   logic [IDW-1:0]   gnt_id;
   logic             gnt_any;
   logic [7:0]       sel_data;
   logic             sel_eol;
   logic             in_frame;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_arb (
      .req        (req_valid),
      .last       (last_q),
      .gnt_onehot (gnt_oh),
      .gnt_id     (gnt_id),
      .any        (gnt_any)
   );

   // mux the winner's byte and eol flag out of the packed inputs
   always_comb begin
      sel_data = '0;
      sel_eol  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_oh[i]) begin
            sel_data = req_data[8*i +: 8];
            sel_eol  = req_eol[i];
         end
      end
   end

   // frame sequencer: grant, then one character per start/busy cycle
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      last_d      = last_q;
      id_d        = id_q;
      data_d      = data_q;
      eol_d       = eol_q;
      cnt_d       = cnt_q;
      req_ready   = '0;
      tx_start    = 1'b0;
      err_timeout = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|req_valid) state_d = ST_GRANT;
         end
         ST_GRANT: begin
            if (gnt_any) begin
               req_ready = gnt_oh;
               last_d    = gnt_id;
               id_d      = gnt_id;
               data_d    = sel_data;
               eol_d     = sel_eol;
               if (TAG_EN) phase_d = PH_TAG;
               else        phase_d = PH_DATA;
               state_d   = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               cnt_d    = '0;
               state_d  = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
               if (cnt_q >= TO_LAST) begin
                  err_timeout = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               if (phase_is_last(phase_q, eol_q)) begin
                  state_d = ST_IDLE;
               end else begin
                  phase_d = phase_next(phase_q);
                  state_d = ST_SEND;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // character presented to the UART for the whole character slot
   always_comb begin
      in_frame = (state_q == ST_SEND) ||
                 (state_q == ST_WAIT_ACK) ||
                 (state_q == ST_WAIT_DONE);
      tx_data  = '0;
      if (in_frame) begin
         tx_data = phase_char(phase_q, 8'(id_q), data_q, EOL_CHAR);
      end
   end

   assign grant_id = id_q;
   assign active   = (state_q != ST_IDLE);

   // state and frame latches, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= PH_TAG;
         last_q  <= LAST_RST;
         id_q    <= '0;
         data_q  <= '0;
         eol_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         last_q  <= last_d;
         id_q    <= id_d;
         data_q  <= data_d;
         eol_q   <= eol_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
